// File: rtl/frame_checker.sv
// Frame checker: lane/pattern/TLAST checks, frame and error counters, first-error capture; 1-cycle registered outputs.
// Never backpressures (TREADY=1 out of reset). FRAME_CHECK_SEQ_EN adds an inter-frame +1 sequence check and a HUNT state.
module frame_checker #(
   parameter int PATTERN_WIDTH  = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int CYCLES_PER_ROW = 4,
   parameter int ROWS_PER_FRAME = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [DATA_WIDTH-1:0]    AXIS_IN_TDATA,
   input  logic                     AXIS_IN_TVALID,
   input  logic                     AXIS_IN_TLAST,
   output logic                     AXIS_IN_TREADY,
   output logic [31:0]              frame_count,
   output logic [31:0]              error_count,
   output logic [2:0]               error_flags,
   output logic [31:0]              first_err_frame,
   output logic [15:0]              first_err_beat,
   output logic                     first_err_valid,
   output logic [PATTERN_WIDTH-1:0] expected_pattern
);

   localparam int LANES = DATA_WIDTH / PATTERN_WIDTH;
   localparam int BW    = (CYCLES_PER_ROW > 1) ? $clog2(CYCLES_PER_ROW) : 1;
   localparam int RW    = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(CYCLES_PER_ROW - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS_PER_FRAME - 1);
   localparam logic [15:0]   CPR16     = 16'(CYCLES_PER_ROW);

   typedef enum logic {ST_RUN = 1'b0, ST_HUNT = 1'b1} state_t;
`ifdef FRAME_CHECK_SEQ_EN
   localparam state_t ST_INIT = ST_HUNT;
`else
   localparam state_t ST_INIT = ST_RUN;
`endif

   state_t                   r_state;
   logic                     r_tready;
   logic [BW-1:0]            r_beat;
   logic [RW-1:0]            r_row;
   logic [PATTERN_WIDTH-1:0] r_expected;
   logic [31:0]              r_frame_count;
   logic [31:0]              r_error_count;
   logic [2:0]               r_error_flags;
   logic [31:0]              r_first_err_frame;
   logic [15:0]              r_first_err_beat;
   logic                     r_first_err_valid;

   logic                     w_accept;
   logic                     w_run;
   logic [PATTERN_WIDTH-1:0] w_lane0;
   logic                     w_frame_start;
   logic                     w_lane_err;
   logic                     w_pat_err;
   logic                     w_seq_err;
   logic                     w_last_exp;
   logic                     w_tlast_err;
   logic                     w_row_end;
   logic                     w_frame_end;
   logic                     w_any_err;
   logic [15:0]              w_beat_idx;

   assign w_accept      = AXIS_IN_TVALID & r_tready;
   assign w_run         = (r_state == ST_RUN);
   assign w_lane0       = AXIS_IN_TDATA[PATTERN_WIDTH-1:0];
   assign w_frame_start = (r_beat == '0) && (r_row == '0);
   assign w_last_exp    = (r_beat == BEAT_LAST);
   assign w_tlast_err   = AXIS_IN_TLAST != w_last_exp;
   // An early TLAST closes the row so the checker resynchronises to the producer.
   assign w_row_end     = w_last_exp | AXIS_IN_TLAST;
   assign w_frame_end   = w_row_end && (r_row == ROW_LAST);
   assign w_beat_idx    = 16'(r_row) * CPR16 + 16'(r_beat);

   always_comb begin
      w_lane_err = 1'b0;
      for (int i = 1; i < LANES; i++) begin
         if (AXIS_IN_TDATA[i*PATTERN_WIDTH +: PATTERN_WIDTH] != w_lane0) w_lane_err = 1'b1;
      end
   end

`ifdef FRAME_CHECK_SEQ_EN
   logic r_seq_valid;
   assign w_seq_err = w_frame_start && r_seq_valid && (w_lane0 != r_expected + 1'b1);
`else
   assign w_seq_err = 1'b0;
`endif

   assign w_pat_err = (!w_frame_start && (w_lane0 != r_expected)) || w_seq_err;
   assign w_any_err = w_lane_err | w_pat_err | w_tlast_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state           <= ST_INIT;
         r_tready          <= 1'b0;
         r_beat            <= '0;
         r_row             <= '0;
         r_expected        <= '0;
         r_frame_count     <= '0;
         r_error_count     <= '0;
         r_error_flags     <= '0;
         r_first_err_frame <= '0;
         r_first_err_beat  <= '0;
         r_first_err_valid <= 1'b0;
`ifdef FRAME_CHECK_SEQ_EN
         r_seq_valid       <= 1'b0;
`endif
      end else begin
         r_tready <= 1'b1;
         if (w_accept) begin
            if (r_state == ST_HUNT) begin
               if (AXIS_IN_TLAST) r_state <= ST_RUN;
            end else begin
               if (w_frame_start) r_expected <= w_lane0;
               if (w_row_end) begin
                  r_beat <= '0;
                  r_row  <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
         end
         // Clear wins over a coincident beat for the software-visible state only.
         if (clear) begin
            r_frame_count     <= '0;
            r_error_count     <= '0;
            r_error_flags     <= '0;
            r_first_err_frame <= '0;
            r_first_err_beat  <= '0;
            r_first_err_valid <= 1'b0;
`ifdef FRAME_CHECK_SEQ_EN
            r_seq_valid       <= 1'b0;
`endif
         end else if (w_accept && w_run) begin
            if (w_frame_end && (r_frame_count != '1)) r_frame_count <= r_frame_count + 1'b1;
            if (w_any_err) begin
               if (r_error_count != '1) r_error_count <= r_error_count + 1'b1;
               r_error_flags <= r_error_flags | {w_tlast_err, w_pat_err, w_lane_err};
               if (!r_first_err_valid) begin
                  r_first_err_valid <= 1'b1;
                  r_first_err_frame <= r_frame_count;
                  r_first_err_beat  <= w_beat_idx;
               end
            end
`ifdef FRAME_CHECK_SEQ_EN
            if (w_frame_start) r_seq_valid <= 1'b1;
`endif
         end
      end
   end

   assign AXIS_IN_TREADY   = r_tready;
   assign frame_count      = r_frame_count;
   assign error_count      = r_error_count;
   assign error_flags      = r_error_flags;
   assign first_err_frame  = r_first_err_frame;
   assign first_err_beat   = r_first_err_beat;
   assign first_err_valid  = r_first_err_valid;
   assign expected_pattern = r_expected;

endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker (default build): per-beat scoreboard of counters/flags plus scenario end-state checks.
module tb_frame_checker;
   localparam int CPR = 4;
   localparam int RPF = 3;
   localparam int BPF = CPR * RPF;

   logic        clk = 1'b0;
   logic        reset, clear, tvalid, tlast, tready;
   logic [63:0] tdata;
   logic [31:0] frame_count, error_count, first_err_frame, expected_pattern;
   logic [2:0]  error_flags;
   logic [15:0] first_err_beat;
   logic        first_err_valid;

   int checks = 0;
   int errors = 0;

   logic [66:0] sb[$];
   logic [66:0] obs[$];

   int          m_beat, m_row;
   logic [31:0] m_fc, m_ec, m_ep, m_ffr;
   logic [2:0]  m_fl;
   logic [15:0] m_fbt;
   logic        m_fv;

   frame_checker #(.PATTERN_WIDTH(32), .DATA_WIDTH(64), .CYCLES_PER_ROW(CPR), .ROWS_PER_FRAME(RPF)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid), .AXIS_IN_TLAST(tlast), .AXIS_IN_TREADY(tready),
      .frame_count(frame_count), .error_count(error_count), .error_flags(error_flags),
      .first_err_frame(first_err_frame), .first_err_beat(first_err_beat),
      .first_err_valid(first_err_valid), .expected_pattern(expected_pattern)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic model_clear();
      m_fc = 0; m_ec = 0; m_fl = 0; m_ffr = 0; m_fbt = 0; m_fv = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_beat = 0; m_row = 0; m_ep = 0;
   endtask

   // Drives one accepted beat, pushes the model's expectation, then records what the DUT shows.
   task automatic drive_beat(input logic [31:0] lo, input logic [31:0] hi, input logic last, input logic clr);
      logic fs, le, pe, te, rend;
      tdata = {hi, lo}; tlast = last; tvalid = 1'b1; clear = clr;
      fs   = (m_beat == 0) && (m_row == 0);
      le   = (hi != lo);
      pe   = !fs && (lo != m_ep);
      te   = (last != (m_beat == CPR - 1));
      rend = last || (m_beat == CPR - 1);
      if (fs) m_ep = lo;
      if (clr) begin
         model_clear();
      end else begin
         if (le || pe || te) begin
            m_ec = m_ec + 1;
            m_fl = m_fl | {te, pe, le};
            if (!m_fv) begin
               m_fv = 1'b1; m_ffr = m_fc; m_fbt = 16'(m_row * CPR + m_beat);
            end
         end
         if (rend && (m_row == RPF - 1)) m_fc = m_fc + 1;
      end
      if (rend) begin
         m_beat = 0;
         m_row  = (m_row == RPF - 1) ? 0 : m_row + 1;
      end else begin
         m_beat = m_beat + 1;
      end
      sb.push_back({m_fc, m_ec, m_fl});
      @(posedge clk); #1;
      obs.push_back({frame_count, error_count, error_flags});
      tvalid = 1'b0; tlast = 1'b0; clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [31:0] pat, input int gap);
      for (int b = 0; b < BPF; b++) begin
         drive_beat(pat, pat, (b % CPR) == CPR - 1, 1'b0);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1; tvalid = 1'b0;
      model_clear();
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic apply_reset(input int cycles);
      int n;
      reset = 1'b1; clear = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
      model_reset();
      repeat (cycles) begin @(posedge clk); #1; end
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL tready_in_reset got=%b want=0", tready); end
      reset = 1'b0;
      n = 0;
      while (tready !== 1'b1 && n < 5) begin @(posedge clk); #1; n++; end
      checks++; if (n != 1) begin errors++; $display("FAIL tready_rise cycles got=%0d want=1", n); end
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
      model_reset();
      repeat (3) @(posedge clk); #1;
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b want=0", tready); end
      checks++; if ({frame_count, error_count, error_flags} !== 67'd0) begin errors++; $display("FAIL reset_counters got=%h want=0", {frame_count, error_count, error_flags}); end
      checks++; if ({first_err_frame, first_err_beat, first_err_valid} !== 49'd0) begin errors++; $display("FAIL reset_capture got=%h want=0", {first_err_frame, first_err_beat, first_err_valid}); end
      checks++; if (expected_pattern !== 32'd0) begin errors++; $display("FAIL reset_pattern got=%h want=0", expected_pattern); end
      apply_reset(1);
   endtask

   task automatic test_clean();
      logic [66:0] e, o;
      for (int f = 0; f < 3; f++) send_frame(32'hA5A5_0001, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL clean_beat got=%h want=%h", o, e); end
      end
      checks++; if (frame_count !== 32'd3) begin errors++; $display("FAIL clean_frames got=%0d want=3", frame_count); end
      checks++; if (error_count !== 32'd0 || error_flags !== 3'b000) begin errors++; $display("FAIL clean_errors got=%0d/%b want=0/000", error_count, error_flags); end
      checks++; if (expected_pattern !== 32'hA5A5_0001) begin errors++; $display("FAIL clean_pattern got=%h want=a5a50001", expected_pattern); end
      checks++; if (first_err_valid !== 1'b0) begin errors++; $display("FAIL clean_capture got=%b want=0", first_err_valid); end
   endtask

   task automatic test_lane_err();
      logic [66:0] e, o;
      do_clear();
      for (int b = 0; b < BPF; b++)
         drive_beat(32'h1111_2222, (b == 5) ? 32'hDEAD_BEEF : 32'h1111_2222, (b % CPR) == CPR - 1, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL lane_beat got=%h want=%h", o, e); end
      end
      checks++; if (error_count !== 32'd1 || error_flags !== 3'b001) begin errors++; $display("FAIL lane_errors got=%0d/%b want=1/001", error_count, error_flags); end
      checks++; if ({first_err_valid, first_err_frame, first_err_beat} !== {1'b1, 32'd0, 16'd5}) begin errors++; $display("FAIL lane_capture got=%b/%0d/%0d want=1/0/5", first_err_valid, first_err_frame, first_err_beat); end
      checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL lane_frames got=%0d want=1", frame_count); end
   endtask

   task automatic test_tlast_err();
      logic [66:0] e, o;
      do_clear();
      send_frame(32'h3333_0000, 0);
      drive_beat(32'h3333_0001, 32'h3333_0001, 1'b0, 1'b0);
      drive_beat(32'h3333_0001, 32'h3333_0001, 1'b1, 1'b0);
      for (int b = 0; b < 2 * CPR; b++)
         drive_beat(32'h3333_0001, 32'h3333_0001, (b % CPR) == CPR - 1, 1'b0);
      send_frame(32'h3333_0002, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL tlast_beat got=%h want=%h", o, e); end
      end
      checks++; if (error_flags !== 3'b100 || error_count !== 32'd1) begin errors++; $display("FAIL tlast_errors got=%0d/%b want=1/100", error_count, error_flags); end
      checks++; if ({first_err_frame, first_err_beat} !== {32'd1, 16'd1}) begin errors++; $display("FAIL tlast_capture got=%0d/%0d want=1/1", first_err_frame, first_err_beat); end
      checks++; if (frame_count !== 32'd3) begin errors++; $display("FAIL tlast_frames got=%0d want=3", frame_count); end
   endtask

   task automatic test_pattern_err();
      logic [66:0] e, o;
      logic [31:0] p;
      p = 32'h0BAD_0000;
      do_clear();
      for (int b = 0; b < BPF; b++) begin
         if (b == 6)      drive_beat(p ^ 32'd1, p ^ 32'd2, 1'b0, 1'b0);
         else if (b == 7) drive_beat(p ^ 32'd4, p ^ 32'd4, 1'b0, 1'b0);
         else             drive_beat(p, p, (b % CPR) == CPR - 1, 1'b0);
      end
      send_frame(32'h0C0C_0000, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL pattern_beat got=%h want=%h", o, e); end
      end
      checks++; if (error_count !== 32'd2 || error_flags !== 3'b111) begin errors++; $display("FAIL pattern_errors got=%0d/%b want=2/111", error_count, error_flags); end
      checks++; if ({first_err_frame, first_err_beat} !== {32'd0, 16'd6}) begin errors++; $display("FAIL pattern_capture got=%0d/%0d want=0/6", first_err_frame, first_err_beat); end
      checks++; if (frame_count !== 32'd2 || expected_pattern !== 32'h0C0C_0000) begin errors++; $display("FAIL pattern_frames got=%0d/%h want=2/0c0c0000", frame_count, expected_pattern); end
   endtask

   task automatic test_valid_toggle();
      logic [66:0] e, o;
      send_frame(32'h4444_0001, 1);
      send_frame(32'h4444_0001, 1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL toggle_beat got=%h want=%h", o, e); end
      end
      checks++; if (frame_count !== 32'd4 || error_count !== 32'd2) begin errors++; $display("FAIL toggle_counts got=%0d/%0d want=4/2", frame_count, error_count); end
      checks++; if (expected_pattern !== 32'h4444_0001) begin errors++; $display("FAIL toggle_pattern got=%h want=44440001", expected_pattern); end
      do_clear();
      checks++; if ({frame_count, error_count, error_flags} !== 67'd0) begin errors++; $display("FAIL clear_counters got=%h want=0", {frame_count, error_count, error_flags}); end
      checks++; if ({first_err_frame, first_err_beat, first_err_valid} !== 49'd0) begin errors++; $display("FAIL clear_capture got=%h want=0", {first_err_frame, first_err_beat, first_err_valid}); end
      checks++; if (expected_pattern !== 32'h4444_0001) begin errors++; $display("FAIL clear_keeps_pattern got=%h want=44440001", expected_pattern); end
   endtask

   task automatic test_clear_collision();
      logic [66:0] e, o;
      drive_beat(32'h7777_0000, 32'h1234_5678, 1'b0, 1'b1);
      checks++; if (error_count !== 32'd0 || expected_pattern !== 32'h7777_0000) begin errors++; $display("FAIL collide_beat got=%0d/%h want=0/77770000", error_count, expected_pattern); end
      for (int b = 1; b < BPF; b++) drive_beat(32'h7777_0000, 32'h7777_0000, (b % CPR) == CPR - 1, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL collide_seq got=%h want=%h", o, e); end
      end
      checks++; if (frame_count !== 32'd1 || error_count !== 32'd0) begin errors++; $display("FAIL collide_frames got=%0d/%0d want=1/0", frame_count, error_count); end
   endtask

   task automatic test_reset_midframe();
      logic [66:0] e, o;
      for (int b = 0; b < 7; b++) drive_beat(32'h5555_0000, 32'h5555_0000, (b % CPR) == CPR - 1, 1'b0);
      apply_reset(2);
      send_frame(32'h6666_0000, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL midreset_beat got=%h want=%h", o, e); end
      end
      checks++; if (frame_count !== 32'd1 || error_count !== 32'd0 || error_flags !== 3'b000) begin errors++; $display("FAIL midreset_counts got=%0d/%0d/%b want=1/0/000", frame_count, error_count, error_flags); end
      checks++; if (expected_pattern !== 32'h6666_0000) begin errors++; $display("FAIL midreset_pattern got=%h want=66660000", expected_pattern); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_lane_err();
      test_tlast_err();
      test_pattern_err();
      test_valid_toggle();
      test_clear_collision();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
